// File: rtl/alarm_ctrl_multi_if.sv
// Bundle of time, alarm and control signals between the time-of-day counter
// side and the multi-alarm controller. The controller uses the slave view.
interface alarm_ctrl_multi_if #(
    parameter int NUM_ALARMS = 2
);
    localparam int SEL_W = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1;

    logic                    one_minute;
    logic [15:0]             current_time;
    logic [16*NUM_ALARMS-1:0] alarm_time;
    logic [NUM_ALARMS-1:0]   alarm_enable;
    logic                    do_snooze;
    logic                    stop_alarm;
    logic                    show_alarm;
    logic [SEL_W-1:0]        show_sel;
    logic [15:0]             display;
    logic                    sound_alarm;
    logic [SEL_W-1:0]        active_alarm;
    logic [3:0]              snooze_count;

    modport master (
        output one_minute, current_time, alarm_time, alarm_enable,
               do_snooze, stop_alarm, show_alarm, show_sel,
        input  display, sound_alarm, active_alarm, snooze_count
    );

    modport slave (
        input  one_minute, current_time, alarm_time, alarm_enable,
               do_snooze, stop_alarm, show_alarm, show_sel,
        output display, sound_alarm, active_alarm, snooze_count
    );
endinterface

// File: rtl/alarm_ctrl_multi.sv
// Multi-channel BCD alarm controller: picks the lowest matching armed alarm,
// rings, snoozes a bounded number of times, times out unanswered rings and
// drives a registered 4-digit display mux.
module alarm_ctrl_multi #(
    parameter int NUM_ALARMS       = 2,
    parameter int SNOOZE_MIN       = 5,
    parameter int MAX_SNOOZES      = 3,
    parameter int RING_TIMEOUT_MIN = 10
) (
    input  logic               clk,
    input  logic               reset,
    alarm_ctrl_multi_if.slave  bus
);
    localparam int SEL_W = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RINGING  = 2'd1,
        SNOOZING = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [15:0]      display_q, display_d;
    logic             sound_q, sound_d;
    logic [SEL_W-1:0] active_q, active_d;
    logic [3:0]       count_q, count_d;
    logic [15:0]      snooze_time_q, snooze_time_d;
    logic [5:0]       ring_min_q, ring_min_d;
    logic             snz_block_q, snz_block_d;

    logic             match_found;
    logic [SEL_W-1:0] match_idx;
    logic             snooze_go;

    // Adds the snooze length to a BCD HH:MM value, wrapping minutes at 60
    // and hours at 24.
    function automatic logic [15:0] bcd_add_minutes(input logic [15:0] t);
        int hours;
        int mins;
        hours = int'(t[15:12]) * 10 + int'(t[11:8]);
        mins  = int'(t[7:4]) * 10 + int'(t[3:0]) + SNOOZE_MIN;
        if (mins >= 60) begin
            mins  = mins - 60;
            hours = hours + 1;
        end
        if (hours >= 24) begin
            hours = hours - 24;
        end
        return {4'(hours / 10), 4'(hours % 10), 4'(mins / 10), 4'(mins % 10)};
    endfunction

    // Finds the lowest-numbered armed alarm equal to the current time;
    // scanning downward lets the lowest index overwrite the others.
    always_comb begin
        match_found = 1'b0;
        match_idx   = '0;
        for (int k = NUM_ALARMS - 1; k >= 0; k--) begin
            if (bus.alarm_enable[k] && (bus.alarm_time[16*k +: 16] == bus.current_time)) begin
                match_found = 1'b1;
                match_idx   = SEL_W'(k);
            end
        end
    end

    // Next-state and episode bookkeeping; a held do_snooze is blocked after it
    // acts once and only re-armed after it has been seen low.
    always_comb begin
        state_d       = state_q;
        active_d      = active_q;
        count_d       = count_q;
        ring_min_d    = ring_min_q;
        snooze_time_d = snooze_time_q;
        snz_block_d   = bus.do_snooze ? snz_block_q : 1'b0;
        snooze_go     = bus.do_snooze && !snz_block_q;

        case (state_q)
            IDLE: begin
                if (!bus.stop_alarm && bus.one_minute && match_found) begin
                    state_d    = RINGING;
                    active_d   = match_idx;
                    ring_min_d = '0;
                    count_d    = '0;
                end
            end
            RINGING: begin
                if (bus.stop_alarm) begin
                    state_d = IDLE;
                end else if (snooze_go) begin
                    snz_block_d = 1'b1;
                    if (count_q < 4'(MAX_SNOOZES)) begin
                        state_d       = SNOOZING;
                        count_d       = count_q + 4'd1;
                        snooze_time_d = bcd_add_minutes(bus.current_time);
                    end else begin
                        state_d = IDLE;
                    end
                end else if (bus.one_minute) begin
                    if ((ring_min_q + 6'd1) == 6'(RING_TIMEOUT_MIN)) begin
                        state_d = IDLE;
                    end else begin
                        ring_min_d = ring_min_q + 6'd1;
                    end
                end
            end
            SNOOZING: begin
                if (bus.stop_alarm) begin
                    state_d = IDLE;
                end else if (bus.one_minute && (bus.current_time == snooze_time_q)) begin
                    state_d    = RINGING;
                    ring_min_d = '0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (state_d == IDLE) begin
            count_d    = '0;
            ring_min_d = '0;
        end
    end

    // Output decode: buzzer follows the next state, display mux follows the
    // inputs, out-of-range selections show zeros.
    always_comb begin
        sound_d   = (state_d == RINGING);
        display_d = bus.current_time;
        if (bus.show_alarm) begin
            display_d = 16'h0000;
            for (int k = 0; k < NUM_ALARMS; k++) begin
                if (bus.show_sel == SEL_W'(k)) begin
                    display_d = bus.alarm_time[16*k +: 16];
                end
            end
        end
    end

    // State and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            display_q     <= 16'h0000;
            sound_q       <= 1'b0;
            active_q      <= '0;
            count_q       <= '0;
            snooze_time_q <= 16'h0000;
            ring_min_q    <= '0;
            snz_block_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            display_q     <= display_d;
            sound_q       <= sound_d;
            active_q      <= active_d;
            count_q       <= count_d;
            snooze_time_q <= snooze_time_d;
            ring_min_q    <= ring_min_d;
            snz_block_q   <= snz_block_d;
        end
    end

    assign bus.display      = display_q;
    assign bus.sound_alarm  = sound_q;
    assign bus.active_alarm = active_q;
    assign bus.snooze_count = count_q;

endmodule

// File: tb/tb_alarm_ctrl_multi.sv
// Bench for alarm_ctrl_multi: directed scenarios plus a randomized run
// against a minutes-of-day episode model.
module tb_alarm_ctrl_multi;
    localparam int N     = 2;
    localparam int SNZ   = 5;
    localparam int MAXS  = 3;
    localparam int TOUT  = 10;
    localparam int SEL_W = (N > 1) ? $clog2(N) : 1;

    typedef enum {EP_IDLE, EP_RINGING, EP_SNOOZING} episode_t;

    logic clk = 1'b0;
    logic reset = 1'b0;

    alarm_ctrl_multi_if #(.NUM_ALARMS(N)) bus();

    alarm_ctrl_multi #(
        .NUM_ALARMS(N), .SNOOZE_MIN(SNZ), .MAX_SNOOZES(MAXS), .RING_TIMEOUT_MIN(TOUT)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cur_min = 0;

    episode_t         m_ep;
    int               m_ring;
    int               m_target;
    bit               m_snz_held;
    logic [15:0]      exp_display;
    logic             exp_sound;
    logic [SEL_W-1:0] exp_active;
    logic [3:0]       exp_count;

    function automatic logic [15:0] to_bcd(input int m);
        int h;
        int mm;
        h  = m / 60;
        mm = m % 60;
        return {4'(h / 10), 4'(h % 10), 4'(mm / 10), 4'(mm % 10)};
    endfunction

    function automatic int to_min(input logic [15:0] b);
        return (int'(b[15:12]) * 10 + int'(b[11:8])) * 60 + int'(b[7:4]) * 10 + int'(b[3:0]);
    endfunction

    task automatic model_reset();
        m_ep        = EP_IDLE;
        m_ring      = 0;
        m_target    = 0;
        m_snz_held  = 1'b0;
        exp_display = 16'h0000;
        exp_sound   = 1'b0;
        exp_active  = '0;
        exp_count   = '0;
    endtask

    // Reference episode model evaluated from the inputs present at a clock edge.
    task automatic model_edge();
        int  w;
        int  s;
        bit  go;
        bit  next_held;
        if (bus.show_alarm) begin
            s = int'(bus.show_sel);
            exp_display = (s < N) ? bus.alarm_time[16*s +: 16] : 16'h0000;
        end else begin
            exp_display = bus.current_time;
        end
        go        = bus.do_snooze && !m_snz_held;
        next_held = bus.do_snooze ? m_snz_held : 1'b0;
        case (m_ep)
            EP_IDLE: begin
                if (bus.one_minute && !bus.stop_alarm) begin
                    w = -1;
                    for (int k = 0; k < N; k++) begin
                        if (w < 0 && bus.alarm_enable[k] &&
                            to_min(bus.alarm_time[16*k +: 16]) == to_min(bus.current_time)) w = k;
                    end
                    if (w >= 0) begin
                        m_ep       = EP_RINGING;
                        exp_active = SEL_W'(w);
                        m_ring     = 0;
                        exp_count  = 0;
                    end
                end
            end
            EP_RINGING: begin
                if (bus.stop_alarm) begin
                    m_ep = EP_IDLE;
                end else if (go) begin
                    next_held = 1'b1;
                    if (int'(exp_count) < MAXS) begin
                        m_ep      = EP_SNOOZING;
                        exp_count = exp_count + 4'd1;
                        m_target  = (to_min(bus.current_time) + SNZ) % 1440;
                    end else begin
                        m_ep = EP_IDLE;
                    end
                end else if (bus.one_minute) begin
                    m_ring++;
                    if (m_ring == TOUT) m_ep = EP_IDLE;
                end
            end
            EP_SNOOZING: begin
                if (bus.stop_alarm) begin
                    m_ep = EP_IDLE;
                end else if (bus.one_minute && to_min(bus.current_time) == m_target) begin
                    m_ep   = EP_RINGING;
                    m_ring = 0;
                end
            end
            default: m_ep = EP_IDLE;
        endcase
        if (m_ep == EP_IDLE) begin
            exp_count = 0;
            m_ring    = 0;
        end
        exp_sound  = (m_ep == EP_RINGING);
        m_snz_held = next_held;
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic set_time(input int m);
        cur_min = m;
        bus.current_time = to_bcd(m);
    endtask

    task automatic set_alarm(input int k, input int m, input bit en);
        bus.alarm_time[16*k +: 16] = to_bcd(m);
        bus.alarm_enable[k] = en;
    endtask

    task automatic minute_pulse();
        set_time((cur_min + 1) % 1440);
        bus.one_minute = 1'b1;
        tick();
        bus.one_minute = 1'b0;
    endtask

    task automatic pulse_snooze();
        bus.do_snooze = 1'b1;
        tick();
        bus.do_snooze = 1'b0;
    endtask

    task automatic pulse_stop();
        bus.stop_alarm = 1'b1;
        tick();
        bus.stop_alarm = 1'b0;
    endtask

    task automatic apply_reset();
        bus.one_minute = 1'b0;
        bus.do_snooze  = 1'b0;
        bus.stop_alarm = 1'b0;
        reset = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    // Starts a ring on alarm 0 at minute m.
    task automatic ring_at(input int m);
        set_alarm(0, m, 1'b1);
        set_time((m + 1439) % 1440);
        tick();
        minute_pulse();
    endtask

    task automatic test_reset();
        bus.current_time = 16'h1234;
        bus.show_alarm = 1'b0;
        tick();
        apply_reset();
        checks++; if (bus.display !== 16'h0000) begin failures++; $display("[TB] FAIL reset_display got=%h exp=0000", bus.display); end
        checks++; if (bus.sound_alarm !== 1'b0) begin failures++; $display("[TB] FAIL reset_sound got=%b exp=0", bus.sound_alarm); end
        checks++; if (bus.active_alarm !== '0) begin failures++; $display("[TB] FAIL reset_active got=%0d exp=0", bus.active_alarm); end
        checks++; if (bus.snooze_count !== 4'd0) begin failures++; $display("[TB] FAIL reset_count got=%0d exp=0", bus.snooze_count); end
    endtask

    task automatic test_basic_match();
        apply_reset();
        set_alarm(1, 0, 1'b0);
        set_alarm(0, 7*60 + 30, 1'b1);
        set_time(7*60 + 29);
        tick();
        checks++; if (bus.sound_alarm !== 1'b0) begin failures++; $display("[TB] FAIL basic_pre got=%b exp=0", bus.sound_alarm); end
        minute_pulse();
        checks++; if (bus.sound_alarm !== 1'b1) begin failures++; $display("[TB] FAIL basic_ring got=%b exp=1", bus.sound_alarm); end
        checks++; if (bus.active_alarm !== 1'b0) begin failures++; $display("[TB] FAIL basic_active got=%0d exp=0", bus.active_alarm); end
        checks++; if (bus.snooze_count !== 4'd0) begin failures++; $display("[TB] FAIL basic_count got=%0d exp=0", bus.snooze_count); end
        checks++; if (bus.display !== 16'h0730) begin failures++; $display("[TB] FAIL basic_display got=%h exp=0730", bus.display); end
        pulse_stop();
        checks++; if (bus.sound_alarm !== 1'b0) begin failures++; $display("[TB] FAIL basic_stop got=%b exp=0", bus.sound_alarm); end
    endtask

    task automatic test_priority();
        apply_reset();
        set_alarm(0, 360, 1'b1);
        set_alarm(1, 360, 1'b1);
        set_time(359);
        tick();
        minute_pulse();
        checks++; if (bus.active_alarm !== 1'b0 || bus.sound_alarm !== 1'b1) begin failures++; $display("[TB] FAIL prio_both got=%0d/%b exp=0/1", bus.active_alarm, bus.sound_alarm); end
        pulse_stop();
        set_alarm(0, 360, 1'b0);
        set_time(359);
        tick();
        minute_pulse();
        checks++; if (bus.active_alarm !== 1'b1 || bus.sound_alarm !== 1'b1) begin failures++; $display("[TB] FAIL prio_alarm1 got=%0d/%b exp=1/1", bus.active_alarm, bus.sound_alarm); end
    endtask

    task automatic test_snooze_wrap();
        apply_reset();
        set_alarm(1, 0, 1'b0);
        ring_at(23*60 + 58);
        pulse_snooze();
        checks++; if (bus.sound_alarm !== 1'b0 || bus.snooze_count !== 4'd1) begin failures++; $display("[TB] FAIL wrap_snooze got=%b/%0d exp=0/1", bus.sound_alarm, bus.snooze_count); end
        repeat (4) minute_pulse();
        checks++; if (bus.sound_alarm !== 1'b0) begin failures++; $display("[TB] FAIL wrap_early got=%b exp=0 at %h", bus.sound_alarm, bus.current_time); end
        minute_pulse();
        checks++; if (bus.sound_alarm !== 1'b1 || bus.current_time !== 16'h0003) begin failures++; $display("[TB] FAIL wrap_ring got=%b at %h exp=1 at 0003", bus.sound_alarm, bus.current_time); end
    endtask

    task automatic test_max_snooze();
        apply_reset();
        ring_at(8*60);
        for (int i = 1; i <= MAXS; i++) begin
            pulse_snooze();
            checks++; if (bus.snooze_count !== 4'(i) || bus.sound_alarm !== 1'b0) begin failures++; $display("[TB] FAIL max_snooze%0d got=%0d/%b exp=%0d/0", i, bus.snooze_count, bus.sound_alarm, i); end
            repeat (SNZ) minute_pulse();
            checks++; if (bus.sound_alarm !== 1'b1) begin failures++; $display("[TB] FAIL max_reraise%0d got=%b exp=1", i, bus.sound_alarm); end
        end
        pulse_snooze();
        checks++; if (bus.sound_alarm !== 1'b0 || bus.snooze_count !== 4'd0) begin failures++; $display("[TB] FAIL max_limit got=%b/%0d exp=0/0", bus.sound_alarm, bus.snooze_count); end
        repeat (SNZ) minute_pulse();
        checks++; if (bus.sound_alarm !== 1'b0) begin failures++; $display("[TB] FAIL max_idle got=%b exp=0", bus.sound_alarm); end
    endtask

    task automatic test_timeout();
        apply_reset();
        ring_at(10*60);
        repeat (TOUT - 1) minute_pulse();
        checks++; if (bus.sound_alarm !== 1'b1) begin failures++; $display("[TB] FAIL timeout_early got=%b exp=1", bus.sound_alarm); end
        minute_pulse();
        checks++; if (bus.sound_alarm !== 1'b0 || bus.snooze_count !== 4'd0) begin failures++; $display("[TB] FAIL timeout_drop got=%b/%0d exp=0/0", bus.sound_alarm, bus.snooze_count); end
    endtask

    task automatic test_stop_snooze_display();
        apply_reset();
        ring_at(11*60);
        pulse_snooze();
        repeat (SNZ) minute_pulse();
        bus.do_snooze  = 1'b1;
        bus.stop_alarm = 1'b1;
        tick();
        bus.do_snooze  = 1'b0;
        bus.stop_alarm = 1'b0;
        checks++; if (bus.sound_alarm !== 1'b0 || bus.snooze_count !== 4'd0) begin failures++; $display("[TB] FAIL both_stop got=%b/%0d exp=0/0", bus.sound_alarm, bus.snooze_count); end
        set_alarm(1, 12*60 + 15, 1'b0);
        bus.show_alarm = 1'b1;
        bus.show_sel   = 1'b1;
        tick();
        checks++; if (bus.display !== 16'h1215) begin failures++; $display("[TB] FAIL disp_alarm1 got=%h exp=1215", bus.display); end
        bus.show_sel = 1'b0;
        tick();
        checks++; if (bus.display !== 16'h1100) begin failures++; $display("[TB] FAIL disp_alarm0 got=%h exp=1100", bus.display); end
        bus.show_alarm = 1'b0;
        tick();
        checks++; if (bus.display !== to_bcd(cur_min)) begin failures++; $display("[TB] FAIL disp_time got=%h exp=%h", bus.display, to_bcd(cur_min)); end
    endtask

    task automatic test_held_snooze();
        apply_reset();
        ring_at(14*60);
        bus.do_snooze = 1'b1;
        tick();
        repeat (SNZ) minute_pulse();
        repeat (3) tick();
        checks++; if (bus.sound_alarm !== 1'b1 || bus.snooze_count !== 4'd1) begin failures++; $display("[TB] FAIL held_noresnooze got=%b/%0d exp=1/1", bus.sound_alarm, bus.snooze_count); end
        bus.do_snooze = 1'b0;
        tick();
        pulse_snooze();
        checks++; if (bus.sound_alarm !== 1'b0 || bus.snooze_count !== 4'd2) begin failures++; $display("[TB] FAIL held_rearm got=%b/%0d exp=0/2", bus.sound_alarm, bus.snooze_count); end
    endtask

    task automatic test_reset_mid_snooze();
        apply_reset();
        ring_at(15*60);
        pulse_snooze();
        repeat (2) minute_pulse();
        apply_reset();
        checks++; if (bus.sound_alarm !== 1'b0 || bus.snooze_count !== 4'd0) begin failures++; $display("[TB] FAIL rst_mid got=%b/%0d exp=0/0", bus.sound_alarm, bus.snooze_count); end
        repeat (SNZ) minute_pulse();
        checks++; if (bus.sound_alarm !== 1'b0) begin failures++; $display("[TB] FAIL rst_noring got=%b exp=0", bus.sound_alarm); end
    endtask

    task automatic test_random();
        apply_reset();
        for (int i = 0; i < 3000; i++) begin
            if (i == 0 || $urandom_range(0, 199) == 0) begin
                set_time(int'($urandom_range(0, 1439)));
                for (int k = 0; k < N; k++)
                    set_alarm(k, (cur_min + int'($urandom_range(1, 12))) % 1440, $urandom_range(0, 3) != 0);
            end
            if ($urandom_range(0, 3) == 0) begin
                set_time((cur_min + 1) % 1440);
                bus.one_minute = 1'b1;
            end else begin
                bus.one_minute = 1'b0;
            end
            if ($urandom_range(0, 7) == 0) bus.do_snooze = ~bus.do_snooze;
            bus.stop_alarm = ($urandom_range(0, 59) == 0);
            bus.show_alarm = 1'($urandom_range(0, 1));
            bus.show_sel   = SEL_W'($urandom_range(0, N - 1));
            tick();
            checks++; if (bus.sound_alarm !== exp_sound) begin failures++; $display("[TB] FAIL rand_sound cyc=%0d got=%b exp=%b", i, bus.sound_alarm, exp_sound); end
            checks++; if (bus.snooze_count !== exp_count) begin failures++; $display("[TB] FAIL rand_count cyc=%0d got=%0d exp=%0d", i, bus.snooze_count, exp_count); end
            checks++; if (bus.active_alarm !== exp_active) begin failures++; $display("[TB] FAIL rand_active cyc=%0d got=%0d exp=%0d", i, bus.active_alarm, exp_active); end
            checks++; if (bus.display !== exp_display) begin failures++; $display("[TB] FAIL rand_display cyc=%0d got=%h exp=%h", i, bus.display, exp_display); end
        end
        bus.one_minute = 1'b0;
        bus.do_snooze  = 1'b0;
        bus.stop_alarm = 1'b0;
    endtask

    // Scenario sequence.
    initial begin
        bus.one_minute   = 1'b0;
        bus.current_time = 16'h0000;
        bus.alarm_time   = '0;
        bus.alarm_enable = '0;
        bus.do_snooze    = 1'b0;
        bus.stop_alarm   = 1'b0;
        bus.show_alarm   = 1'b0;
        bus.show_sel     = '0;
        model_reset();
        #1;
        test_reset();
        test_basic_match();
        test_priority();
        test_snooze_wrap();
        test_max_snooze();
        test_timeout();
        test_stop_snooze_display();
        test_held_snooze();
        test_reset_mid_snooze();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/alarm_ctrl_multi.md
Name: alarm_ctrl_multi

Overview:
- Parametrised successor to the single-alarm display driver.
- Supports NUM_ALARMS independent BCD HH:MM alarms, each with its own enable.
- Provides programmable snooze length, a snooze limit and a ring auto-timeout.
- Sits between the BCD time-of-day counter and the 4-digit display / buzzer; fully synchronous, all outputs registered.

Parameters:
- NUM_ALARMS, 2, number of alarm channels (1..8).
- SNOOZE_MIN, 5, minutes added per snooze (1..59).
- MAX_SNOOZES, 3, snoozes allowed per ring episode (1..15); further do_snooze acts as stop.
- RING_TIMEOUT_MIN, 10, minutes of unanswered ringing before automatic return to IDLE (1..59).

Ports:
- clk, input, 1: system clock; all state on the rising edge.
- reset, input, 1: asynchronous, active-high; forces every register to its reset value.
- one_minute, input, 1: single-cycle pulse, coincident with the cycle in which current_time shows the new minute.
- current_time, input, 16: BCD {Hh,Hl,Mh,Ml}, 00:00..23:59.
- alarm_time, input, 16*NUM_ALARMS: alarm k in bits [16k+15:16k], same BCD format.
- alarm_enable, input, NUM_ALARMS: bit k arms alarm k.
- do_snooze, input, 1: level or pulse; sampled every cycle.
- stop_alarm, input, 1: level or pulse; sampled every cycle.
- show_alarm, input, 1: 1 = display the selected alarm, 0 = display current_time.
- show_sel, input, SEL_W: alarm index shown when show_alarm=1. SEL_W = max(1, clog2(NUM_ALARMS)).
- display, output, 16: registered BCD display value.
- sound_alarm, output, 1: buzzer drive; high only in RINGING.
- active_alarm, output, SEL_W: index of the alarm owning the current episode.
- snooze_count, output, 4: snoozes used in the current episode.

Behaviour:
- Reset values: state=IDLE, display=16'h0000, sound_alarm=0, active_alarm=0, snooze_count=0, snooze_time=16'h0000, ring_min=0.
- Inputs are valid BCD by contract; there is no range checking. show_sel >= NUM_ALARMS displays 16'h0000.
- Match condition: one_minute=1 and alarm_enable[k]=1 and alarm_time[k]==current_time. When several alarms match, the lowest k wins.
- Event priority within one cycle: stop_alarm > do_snooze > one_minute-driven transitions.
- States:
  - IDLE: on a match, go to RINGING; active_alarm=k, ring_min=0, snooze_count=0.
  - RINGING:
    - stop_alarm: go to IDLE.
    - do_snooze with snooze_count<MAX_SNOOZES: go to SNOOZING; snooze_count+1; snooze_time=current_time+SNOOZE_MIN.
    - do_snooze with snooze_count==MAX_SNOOZES: go to IDLE.
    - one_minute: ring_min+1; if ring_min+1==RING_TIMEOUT_MIN, go to IDLE.
  - SNOOZING:
    - stop_alarm: go to IDLE.
    - one_minute with current_time==snooze_time: go to RINGING; ring_min=0.
    - do_snooze is ignored.
- Episode ownership: alarm matches in RINGING or SNOOZING are ignored, including other channels and the same channel.
- Clearing alarm_enable mid-episode does not cancel the episode.
- On any return to IDLE: snooze_count=0 and ring_min=0. active_alarm holds its last value.
- sound_alarm is registered: it rises the cycle after the transition into RINGING and falls the cycle after leaving it.
- do_snooze/stop_alarm held high across many cycles acts once per state. Example: a held do_snooze does not re-snooze after SNOOZING→RINGING until it has been seen low for at least one cycle (edge-qualified internally).
- Snooze arithmetic: BCD time + SNOOZE_MIN minutes, modulo 24h. Minutes carry at 60, hours wrap 23→00; e.g. 23:58+5 = 00:03, 09:57+5 = 10:02.
- Display: one-cycle latency. display <= show_alarm ? alarm_time[show_sel] : current_time, updated every cycle regardless of state.
- Reset asserted mid-episode: immediate return to reset values, no ringing after release until a fresh match.
- A match in the same cycle as reset deassertion is not required to be captured.

Test Plan:
- Reset, alarm0=07:30 enabled, current_time steps 07:29→07:30 with one_minute → sound_alarm=1 one cycle later, active_alarm=0, snooze_count=0.
- Alarm0=alarm1=06:00, both enabled, match → active_alarm=0. Repeat with alarm0 disabled → active_alarm=1.
- Ringing at 23:58, do_snooze → sound_alarm=0, snooze_count=1. one_minute stepped to 00:03 → sound_alarm=1 again.
- MAX_SNOOZES=3: snooze three times, ring again, fourth do_snooze → IDLE, sound_alarm=0, snooze_count=0.
- Ringing, no response for 10 one_minute pulses → sound_alarm drops after the 10th pulse.
- do_snooze and stop_alarm asserted together while ringing → IDLE, snooze_count=0. show_alarm=1, show_sel=1, alarm1=12:15 → display=16'h1215 the following cycle. Reset asserted mid-SNOOZING → sound_alarm=0 and no ring at snooze_time.
